piece_controller: RTL and testbench
===================================

PIECE_CONTROLLER -- requirements
Module: piece_controller

Interface
REQ-001 Parameter COLS, default 12, board width in squares.
REQ-002 Parameter ROWS, default 18, board height in squares.
REQ-003 Parameter GRAVITY_FRAMES, default 30, frame edges per automatic one-row fall.
REQ-004 Clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 frame_tick  input  1  vertical-sync-rate signal; its rising edge is the frame event.
REQ-007 start  input  1  spawn-request level; acted on only in IDLE.
REQ-008 piece_type  input  3  tetromino select, latched at spawn.
REQ-009 key_left, key_right, key_down  input  1 each  move requests, sampled only on frame events.
REQ-010 blockx1..blockx4, blocky1..blocky4  output  10 each  board-square column/row of each of the four squares, registered.
REQ-011 active  output  1  high while a piece is falling (PLAY).
REQ-012 locked  output  1  one-Clk pulse when the piece lands.

Function
REQ-013 Frame event = frame_tick high on this Clk edge and low on the previous Clk edge (one registered sample); exactly one event per frame_tick rise.
REQ-014 Internal state: anchor ax (0..COLS-1), ay (0..ROWS-1), latched type, gravity counter (0..GRAVITY_FRAMES-1).
REQ-015 Square offsets (dx,dy) per type: 0 I (0,0)(1,0)(2,0)(3,0); 1 O (0,0)(1,0)(0,1)(1,1); 2 T (0,0)(1,0)(2,0)(1,1); 3 S (1,0)(2,0)(0,1)(1,1); 4 Z (0,0)(1,0)(1,1)(2,1); 5 J (0,0)(0,1)(1,1)(2,1); 6 L (2,0)(0,1)(1,1)(2,1); 7 treated as O.
REQ-016 Extents: width w = 4 for I, 2 for O/7, 3 otherwise; height h = 1 for I, 2 otherwise.
REQ-017 blockxN = ax+dxN, blockyN = ay+dyN, zero-extended to 10 bits, updated on the same Clk edge as the anchor change (one-Clk latency from the frame event).
REQ-018 States: IDLE, SPAWN, PLAY, LOCK.
REQ-019 IDLE: start=1 -> SPAWN, latching piece_type; outputs hold last values.
REQ-020 SPAWN (one Clk): ax=4, ay=0, counter=0, outputs loaded with spawn squares -> PLAY.
REQ-021 PLAY, per frame event, horizontal first: left=1,right=0 and ax>0 -> ax-1; right=1,left=0 and ax+w<COLS -> ax+1; both or neither -> no change.
REQ-022 PLAY, same event, vertical: fall if key_down=1 or counter=GRAVITY_FRAMES-1, else counter+1.
REQ-023 Fall with ay+h<ROWS -> ay+1, counter=0; fall with ay+h=ROWS -> no move, counter=0, -> LOCK.
REQ-024 Horizontal and vertical changes in the same event both apply, in one Clk.
REQ-025 LOCK (one Clk): locked=1, -> IDLE; block outputs keep the landed position.
REQ-026 active=1 exactly in PLAY; start outside IDLE ignored; no frame events processed in IDLE, SPAWN, LOCK.

Reset
REQ-027 Reset=1 forces IDLE, ax=ay=0, type=0, counter=0, all block outputs 0, active=0, locked=0, edge sampler 0, immediately regardless of Clk.
REQ-028 Reset mid-PLAY or mid-LOCK discards the piece; no locked pulse is issued.

Verification
REQ-029 Reset, start=1, piece_type=1 -> after 2 Clk active=1, squares (4,0)(5,0)(4,1)(5,1).
REQ-030 Type 0 spawned, 30 frame events, no keys -> ay=1 after 30th event only; squares (4,1)(5,1)(6,1)(7,1).
REQ-031 Type 0, key_left held 6 events -> ax 3,2,1,0,0,0; then key_right held 10 events -> ax stops at 8 (COLS-w); both keys -> no change.
REQ-032 Type 1, key_down held -> ay reaches 16 after 16 events; 17th event: locked pulse 1 Clk, active=0, squares stay (4,16)(5,16)(4,17)(5,17).
REQ-033 frame_tick held high 50 Clk -> exactly one event; key_left and key_down on one event -> ax-1 and ay+1 in one Clk.
REQ-034 Reset asserted in PLAY at ay=7 -> all outputs 0 asynchronously, no locked pulse; start after release spawns normally.

Source files
------------

// File: rtl/piece_controller.sv
// Falling-tetromino controller: spawns a piece, applies moves and gravity on frame
// events, and reports the four board squares and a one-cycle landing pulse.
module piece_controller #(
  parameter int COLS           = 12,
  parameter int ROWS           = 18,
  parameter int GRAVITY_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [2:0] piece_type,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_down,
  output logic [9:0] blockx1,
  output logic [9:0] blockx2,
  output logic [9:0] blockx3,
  output logic [9:0] blockx4,
  output logic [9:0] blocky1,
  output logic [9:0] blocky2,
  output logic [9:0] blocky3,
  output logic [9:0] blocky4,
  output logic       active,
  output logic       locked,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE, SPAWN, PLAY, LOCK} state_t;

  localparam int CW = (GRAVITY_FRAMES > 1) ? $clog2(GRAVITY_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(GRAVITY_FRAMES - 1);
  localparam logic [9:0] COLS_W = 10'(COLS);
  localparam logic [9:0] ROWS_W = 10'(ROWS);

  state_t          state, state_n;
  logic            frame_q;
  logic            frame_ev;
  logic [9:0]      ax, ay, ax_n, ay_n;
  logic [2:0]      ptype, ptype_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [7:0]      dxs, dys;
  logic [9:0]      w, h;

  assign frame_ev  = frame_tick & ~frame_q;
  assign dbg_state = state;

  // Offsets are packed square1..square4, two bits each, MSB first.
  always_comb begin
    dxs = 8'd0;
    dys = 8'd0;
    w   = 10'd3;
    h   = 10'd2;
    case (ptype_n)
      3'd0: begin dxs = {2'd0, 2'd1, 2'd2, 2'd3}; dys = 8'd0; w = 10'd4; h = 10'd1; end
      3'd2: begin dxs = {2'd0, 2'd1, 2'd2, 2'd1}; dys = {2'd0, 2'd0, 2'd0, 2'd1}; end
      3'd3: begin dxs = {2'd1, 2'd2, 2'd0, 2'd1}; dys = {2'd0, 2'd0, 2'd1, 2'd1}; end
      3'd4: begin dxs = {2'd0, 2'd1, 2'd1, 2'd2}; dys = {2'd0, 2'd0, 2'd1, 2'd1}; end
      3'd5: begin dxs = {2'd0, 2'd0, 2'd1, 2'd2}; dys = {2'd0, 2'd1, 2'd1, 2'd1}; end
      3'd6: begin dxs = {2'd2, 2'd0, 2'd1, 2'd2}; dys = {2'd0, 2'd1, 2'd1, 2'd1}; end
      default: begin dxs = {2'd0, 2'd1, 2'd0, 2'd1}; dys = {2'd0, 2'd0, 2'd1, 2'd1}; w = 10'd2; end
    endcase
  end

  always_comb begin
    state_n = state;
    ax_n    = ax;
    ay_n    = ay;
    ptype_n = ptype;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          ptype_n = piece_type;
          state_n = SPAWN;
        end
      end
      SPAWN: begin
        ax_n    = 10'd4;
        ay_n    = 10'd0;
        cnt_n   = '0;
        state_n = PLAY;
      end
      PLAY: begin
        if (frame_ev) begin
          if (key_left && !key_right && ax != 10'd0)
            ax_n = ax - 10'd1;
          else if (key_right && !key_left && (ax + w) < COLS_W)
            ax_n = ax + 10'd1;
          if (key_down || cnt == CNT_MAX) begin
            cnt_n = '0;
            if ((ay + h) < ROWS_W) ay_n = ay + 10'd1;
            else                   state_n = LOCK;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      LOCK:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      frame_q <= 1'b0;
      ax      <= 10'd0;
      ay      <= 10'd0;
      ptype   <= 3'd0;
      cnt     <= '0;
      active  <= 1'b0;
      locked  <= 1'b0;
      blockx1 <= 10'd0;
      blockx2 <= 10'd0;
      blockx3 <= 10'd0;
      blockx4 <= 10'd0;
      blocky1 <= 10'd0;
      blocky2 <= 10'd0;
      blocky3 <= 10'd0;
      blocky4 <= 10'd0;
    end else begin
      state   <= state_n;
      frame_q <= frame_tick;
      ax      <= ax_n;
      ay      <= ay_n;
      ptype   <= ptype_n;
      cnt     <= cnt_n;
      active  <= (state_n == PLAY);
      locked  <= (state_n == LOCK);
      // Squares follow the anchor only while a piece is being placed or moved.
      if (state == SPAWN || state == PLAY) begin
        blockx1 <= ax_n + {8'd0, dxs[7:6]};
        blockx2 <= ax_n + {8'd0, dxs[5:4]};
        blockx3 <= ax_n + {8'd0, dxs[3:2]};
        blockx4 <= ax_n + {8'd0, dxs[1:0]};
        blocky1 <= ay_n + {8'd0, dys[7:6]};
        blocky2 <= ay_n + {8'd0, dys[5:4]};
        blocky3 <= ay_n + {8'd0, dys[3:2]};
        blocky4 <= ay_n + {8'd0, dys[1:0]};
      end
    end
  end

endmodule

// File: tb/tb_piece_controller.sv
// Directed bench for piece_controller: spawn, gravity, moves, walls, landing,
// frame-edge detection and asynchronous reset.
module tb_piece_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [2:0] piece_type = 3'd0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_down = 1'b0;
  logic [9:0] blockx1, blockx2, blockx3, blockx4;
  logic [9:0] blocky1, blocky2, blocky3, blocky4;
  logic       active, locked;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  piece_controller #(.COLS(12), .ROWS(18), .GRAVITY_FRAMES(30)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .piece_type(piece_type), .key_left(key_left), .key_right(key_right),
    .key_down(key_down),
    .blockx1(blockx1), .blockx2(blockx2), .blockx3(blockx3), .blockx4(blockx4),
    .blocky1(blocky1), .blocky2(blocky2), .blocky3(blocky3), .blocky4(blocky4),
    .active(active), .locked(locked), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [79:0] sq(input int x1, input int y1, input int x2, input int y2,
                                     input int x3, input int y3, input int x4, input int y4);
    sq = {10'(x1), 10'(x2), 10'(x3), 10'(x4), 10'(y1), 10'(y2), 10'(y3), 10'(y4)};
  endfunction

  function automatic logic [79:0] obs_sq();
    obs_sq = {blockx1, blockx2, blockx3, blockx4, blocky1, blocky2, blocky3, blocky4};
  endfunction

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame_tick rise; returns just after the edge that detects it.
  task automatic frame_event();
    @(posedge clk); #1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic spawn(input logic [2:0] t);
    piece_type = t;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int exp_ax[6] = '{3, 2, 1, 0, 0, 0};

    // Asynchronous reset before any clock edge
    #3 reset = 1'b1;
    #1;
    check("rst_squares", obs_sq(), 80'd0);
    check("rst_active", 80'(active), 80'd0);
    check("rst_locked", 80'(locked), 80'd0);
    check("rst_state", 80'(dbg_state), 80'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // O piece spawn
    spawn(3'd1);
    check("o_spawn_active", 80'(active), 80'd1);
    check("o_spawn_sq", obs_sq(), sq(4, 0, 5, 0, 4, 1, 5, 1));

    // Soft drop to the floor
    key_down = 1'b1;
    repeat (16) frame_event();
    check("o_drop16_y", 80'(blocky1), 80'd16);
    check("o_drop16_active", 80'(active), 80'd1);
    frame_event();
    check("o_lock_pulse", 80'(locked), 80'd1);
    check("o_lock_active", 80'(active), 80'd0);
    check("o_lock_sq", obs_sq(), sq(4, 16, 5, 16, 4, 17, 5, 17));
    @(posedge clk); #1;
    check("o_lock_pulse_end", 80'(locked), 80'd0);
    check("o_idle_state", 80'(dbg_state), 80'd0);
    check("o_idle_sq", obs_sq(), sq(4, 16, 5, 16, 4, 17, 5, 17));

    // Frame events in IDLE are ignored
    key_left = 1'b1;
    frame_event();
    check("idle_ignore_sq", obs_sq(), sq(4, 16, 5, 16, 4, 17, 5, 17));
    key_left = 1'b0;
    key_down = 1'b0;

    // I piece: gravity after exactly 30 events
    spawn(3'd0);
    check("i_spawn_sq", obs_sq(), sq(4, 0, 5, 0, 6, 0, 7, 0));
    repeat (29) frame_event();
    check("i_grav29_y", 80'(blocky1), 80'd0);
    frame_event();
    check("i_grav30_sq", obs_sq(), sq(4, 1, 5, 1, 6, 1, 7, 1));

    // Left wall
    key_left = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame_event();
      check($sformatf("i_left%0d_x", i), 80'(blockx1), 80'(exp_ax[i]));
    end
    key_left = 1'b0;

    // Right wall at COLS-w
    key_right = 1'b1;
    repeat (10) frame_event();
    check("i_right_sq", obs_sq(), sq(8, 1, 9, 1, 10, 1, 11, 1));
    key_left = 1'b1;
    frame_event();
    check("i_both_x", 80'(blockx1), 80'd8);
    key_right = 1'b0;

    // frame_tick held high: one event, left and down together
    key_down = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b1;
    @(posedge clk); #1;
    check("held_first_sq", obs_sq(), sq(7, 2, 8, 2, 9, 2, 10, 2));
    repeat (49) @(posedge clk);
    #1;
    check("held_50_sq", obs_sq(), sq(7, 2, 8, 2, 9, 2, 10, 2));
    frame_tick = 1'b0;
    key_left = 1'b0;

    // Drop to row 7, then reset mid-play
    repeat (5) frame_event();
    check("i_row7_y", 80'(blocky1), 80'd7);
    check("i_row7_active", 80'(active), 80'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_sq", obs_sq(), 80'd0);
    check("midrst_active", 80'(active), 80'd0);
    check("midrst_locked", 80'(locked), 80'd0);
    check("midrst_state", 80'(dbg_state), 80'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_hold_locked", 80'(locked), 80'd0);
    reset = 1'b0;
    key_down = 1'b0;

    // T piece after reset; start during PLAY ignored
    spawn(3'd2);
    check("t_spawn_sq", obs_sq(), sq(4, 0, 5, 0, 6, 0, 5, 1));
    check("t_spawn_active", 80'(active), 80'd1);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    check("t_start_ignored_state", 80'(dbg_state), 80'd2);
    check("t_start_ignored_sq", obs_sq(), sq(4, 0, 5, 0, 6, 0, 5, 1));
    key_right = 1'b1;
    repeat (6) frame_event();
    key_right = 1'b0;
    check("t_right_sq", obs_sq(), sq(9, 0, 10, 0, 11, 0, 10, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
